// File: rtl/dmem_responder_if.sv
// Request/response handshake bundle between the CPU memory stage (master)
// and the data memory responder (slave).
interface dmem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_wen;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_wen, req_addr, req_wdata, req_be, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_wen, req_addr, req_wdata, req_be, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_responder.sv
// Word-addressed data memory with a valid/ready handshake and a fixed number
// of wait states between accepting a request and returning its single response.
module dmem_responder #(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  dmem_responder_if.slave   bus
);

  localparam int          DEPTH     = 1 << ADDR_WIDTH;
  localparam logic [3:0]  WAIT_INIT = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        wen_q, wen_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;
  logic        req_ready_q, req_ready_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        rsp_err_q, rsp_err_d;

  logic                  commit_s;
  logic                  c_wen_s;
  logic [31:0]           c_addr_s;
  logic [31:0]           c_wdata_s;
  logic [3:0]            c_be_s;
  logic                  err_s;
  logic [ADDR_WIDTH-1:0] idx_s;
  logic                  mem_we_s;

  logic [31:0] mem [DEPTH];

  function automatic logic addr_err(input logic [31:0] a);
    return (a[1:0] != 2'd0) || ((a >> (ADDR_WIDTH + 2)) != 32'd0);
  endfunction

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                              input logic [31:0] new_w,
                                              input logic [3:0]  be);
    logic [31:0] res;
    for (int i = 0; i < 4; i++) begin
      res[8*i +: 8] = be[i] ? new_w[8*i +: 8] : old_w[8*i +: 8];
    end
    return res;
  endfunction

  assign bus.req_ready = req_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;

  // With zero wait states the commit uses the live request on its acceptance edge.
  assign c_wen_s   = (state_q == IDLE) ? bus.req_wen   : wen_q;
  assign c_addr_s  = (state_q == IDLE) ? bus.req_addr  : addr_q;
  assign c_wdata_s = (state_q == IDLE) ? bus.req_wdata : wdata_q;
  assign c_be_s    = (state_q == IDLE) ? bus.req_be    : be_q;
  assign err_s     = addr_err(c_addr_s);
  assign idx_s     = c_addr_s[ADDR_WIDTH+1:2];
  assign mem_we_s  = commit_s && c_wen_s && !err_s && !rst;

  // Next-state, request latch, commit and response computation.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    wen_d       = wen_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    be_d        = be_q;
    req_ready_d = req_ready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    commit_s    = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          wen_d       = bus.req_wen;
          addr_d      = bus.req_addr;
          wdata_d     = bus.req_wdata;
          be_d        = bus.req_be;
          cnt_d       = WAIT_INIT;
          req_ready_d = 1'b0;
          if (WAIT_CYCLES == 0) begin
            state_d  = RESP;
            commit_s = 1'b1;
          end else begin
            state_d  = WAIT;
          end
        end else begin
          req_ready_d = 1'b1;
        end
      end
      WAIT: begin
        if (cnt_q <= 4'd1) begin
          cnt_d    = 4'd0;
          state_d  = RESP;
          commit_s = 1'b1;
        end else begin
          cnt_d    = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          state_d     = IDLE;
          req_ready_d = 1'b1;
          rsp_valid_d = 1'b0;
          rsp_rdata_d = 32'd0;
          rsp_err_d   = 1'b0;
        end else begin
          state_d     = RESP;
        end
      end
      default: begin
        state_d     = IDLE;
        cnt_d       = 4'd0;
        req_ready_d = 1'b1;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = 32'd0;
        rsp_err_d   = 1'b0;
      end
    endcase

    if (commit_s) begin
      rsp_valid_d = 1'b1;
      rsp_err_d   = err_s;
      rsp_rdata_d = (err_s || c_wen_s) ? 32'd0 : mem[idx_s];
    end else begin
      rsp_valid_d = rsp_valid_d;
    end
  end

  // Control state and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      wen_q       <= 1'b0;
      addr_q      <= 32'd0;
      wdata_q     <= 32'd0;
      be_q        <= 4'd0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'd0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      wen_q       <= wen_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      be_q        <= be_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // Storage array; contents are deliberately left unreset.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem[idx_s] <= merge_bytes(mem[idx_s], c_wdata_s, c_be_s);
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed scoreboard bench for dmem_responder with two wait-state settings.
module tb_dmem_responder;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dmem_responder_if bus2();
  dmem_responder_if bus0();

  dmem_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(2)) dut2 (
    .clk(clk), .rst(rst), .bus(bus2.slave)
  );
  dmem_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .bus(bus0.slave)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  logic [32:0] sb[$];

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL global_timeout observed=running required=finished");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic req2(input logic wen, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [3:0] be, input logic [31:0] exp_rd, input logic exp_err,
                      input int hold);
    logic [32:0] e;
    int lat;
    @(negedge clk);
    chk("req_ready_idle", {31'd0, bus2.req_ready}, 32'd1);
    bus2.rsp_ready = (hold == 0);
    bus2.req_valid = 1'b1;
    bus2.req_wen   = wen;
    bus2.req_addr  = addr;
    bus2.req_wdata = wdata;
    bus2.req_be    = be;
    sb.push_back({exp_err, exp_rd});
    @(posedge clk); #1;
    bus2.req_valid = 1'b0;
    bus2.req_wen   = ~wen;
    bus2.req_addr  = $urandom;
    bus2.req_wdata = $urandom;
    bus2.req_be    = ~be;
    lat = 0;
    while (bus2.rsp_valid !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", 32'(lat), 32'd2);
    e = sb.pop_front();
    chk("rsp_rdata", bus2.rsp_rdata, e[31:0]);
    chk("rsp_err", {31'd0, bus2.rsp_err}, {31'd0, e[32]});
    for (int k = 0; k < hold; k++) begin
      @(posedge clk); #1;
      chk("hold_valid", {31'd0, bus2.rsp_valid}, 32'd1);
      chk("hold_rdata", bus2.rsp_rdata, e[31:0]);
      chk("hold_err", {31'd0, bus2.rsp_err}, {31'd0, e[32]});
      chk("hold_req_ready", {31'd0, bus2.req_ready}, 32'd0);
    end
    bus2.rsp_ready = 1'b1;
    @(posedge clk); #1;
    chk("rsp_valid_after_hs", {31'd0, bus2.rsp_valid}, 32'd0);
    chk("req_ready_after_hs", {31'd0, bus2.req_ready}, 32'd1);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_req_ready"}, {31'd0, bus2.req_ready}, 32'd1);
    chk({tag, "_rsp_valid"}, {31'd0, bus2.rsp_valid}, 32'd0);
    chk({tag, "_rsp_rdata"}, bus2.rsp_rdata, 32'd0);
    chk({tag, "_rsp_err"},   {31'd0, bus2.rsp_err}, 32'd0);
  endtask

  initial begin
    logic [31:0] vals[8];
    logic [32:0] e;
    int          lat;
    int          prev;
    logic        w;
    logic [31:0] a;
    logic [31:0] d;

    rst = 1'b1;
    bus2.req_valid = 1'b0; bus2.req_wen = 1'b0; bus2.req_addr = 32'd0;
    bus2.req_wdata = 32'd0; bus2.req_be = 4'd0; bus2.rsp_ready = 1'b1;
    bus0.req_valid = 1'b0; bus0.req_wen = 1'b0; bus0.req_addr = 32'd0;
    bus0.req_wdata = 32'd0; bus0.req_be = 4'd0; bus0.rsp_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk_reset_vals("reset");
    chk("reset_w0_req_ready", {31'd0, bus0.req_ready}, 32'd1);
    chk("reset_w0_rsp_valid", {31'd0, bus0.rsp_valid}, 32'd0);
    rst = 1'b0;

    // Full store then load, partial store merge
    req2(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 32'd0, 1'b0, 0);
    req2(1'b0, 32'h10, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0, 0);
    req2(1'b1, 32'h20, 32'h11223344, 4'hF, 32'd0, 1'b0, 0);
    req2(1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, 32'd0, 1'b0, 0);
    req2(1'b0, 32'h20, 32'h0, 4'hF, 32'h11BB33DD, 1'b0, 0);

    // Error cases and no-op store leave memory untouched
    req2(1'b0, 32'h13, 32'h0, 4'hF, 32'd0, 1'b1, 0);
    req2(1'b1, 32'h11, 32'hCAFEF00D, 4'hF, 32'd0, 1'b1, 0);
    req2(1'b0, 32'h10, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0, 0);
    req2(1'b1, 32'h0, 32'h12345678, 4'hF, 32'd0, 1'b0, 0);
    req2(1'b1, 32'h4000, 32'hFFFFFFFF, 4'hF, 32'd0, 1'b1, 0);
    req2(1'b0, 32'h0, 32'h0, 4'h0, 32'h12345678, 1'b0, 0);
    req2(1'b1, 32'h10, 32'h0BADF00D, 4'h0, 32'd0, 1'b0, 0);
    req2(1'b0, 32'h10, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0, 0);

    // Backpressure
    req2(1'b0, 32'h20, 32'h0, 4'h0, 32'h11BB33DD, 1'b0, 5);

    // Reset during WAIT drops the store
    req2(1'b1, 32'h8, 32'h0, 4'hF, 32'd0, 1'b0, 0);
    @(negedge clk);
    bus2.req_valid = 1'b1; bus2.req_wen = 1'b1; bus2.req_addr = 32'h8;
    bus2.req_wdata = 32'h55; bus2.req_be = 4'hF;
    @(posedge clk); #1;
    bus2.req_valid = 1'b0;
    #1 rst = 1'b1;
    #1 chk_reset_vals("rst_in_wait");
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    req2(1'b0, 32'h8, 32'h0, 4'h0, 32'h0, 1'b0, 0);

    // Reset during RESP keeps the committed store
    @(negedge clk);
    bus2.rsp_ready = 1'b0;
    bus2.req_valid = 1'b1; bus2.req_wen = 1'b1; bus2.req_addr = 32'hC;
    bus2.req_wdata = 32'h77; bus2.req_be = 4'hF;
    @(posedge clk); #1;
    bus2.req_valid = 1'b0;
    lat = 0;
    while (bus2.rsp_valid !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("resp_before_rst", {31'd0, bus2.rsp_valid}, 32'd1);
    rst = 1'b1;
    #1 chk_reset_vals("rst_in_resp");
    @(negedge clk);
    rst = 1'b0;
    bus2.rsp_ready = 1'b1;
    req2(1'b0, 32'hC, 32'h0, 4'h0, 32'h77, 1'b0, 0);

    // Zero wait states: 8 stores then 8 streamed loads, one response per 2 cycles
    for (int i = 0; i < 8; i++) vals[i] = $urandom;
    @(negedge clk);
    prev = 0;
    for (int i = 0; i < 16; i++) begin
      w = (i < 8);
      a = 32'((i % 8) * 4);
      d = vals[i % 8];
      bus0.req_valid = 1'b1;
      bus0.req_wen   = w;
      bus0.req_addr  = a;
      bus0.req_wdata = d;
      bus0.req_be    = 4'hF;
      sb.push_back({1'b0, (w ? 32'd0 : d)});
      @(posedge clk); #1;
      chk("w0_latency", {31'd0, bus0.rsp_valid}, 32'd1);
      e = sb.pop_front();
      chk("w0_rdata", bus0.rsp_rdata, e[31:0]);
      chk("w0_err", {31'd0, bus0.rsp_err}, {31'd0, e[32]});
      if (i > 0) chk("w0_period", 32'(cyc - prev), 32'd2);
      prev = cyc;
      @(posedge clk); #1;
    end
    bus0.req_valid = 1'b0;
    chk("w0_idle_ready", {31'd0, bus0.req_ready}, 32'd1);
    chk("w0_idle_valid", {31'd0, bus0.rsp_valid}, 32'd0);

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Word-addressed data memory responder with a valid/ready request/response handshake and programmable wait states. Serves load/store requests from the CPU's memory-access stage, replacing the zero-latency data memory so the core can be exercised against realistic, stalling memory. Each request is accepted, delayed by a fixed number of wait cycles, committed, and then returned as exactly one response. Illegal requests are flagged with an error response.

## Interface

- `ADDR_WIDTH`, 10: log2 of the word depth; memory holds 2^ADDR_WIDTH 32-bit words.
- `WAIT_CYCLES`, 2: wait states between acceptance and response; legal range 0..15.

- `clk`  in  1  single clock; all state changes on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  responder can accept a request.
- `req_wen`  in  1  1 = store, 0 = load.
- `req_addr`  in  32  byte address.
- `req_wdata`  in  32  store data.
- `req_be`  in  4  byte enables for stores; bit i selects byte [8i+7:8i].
- `rsp_valid`  out  1  response present.
- `rsp_ready`  in  1  requester accepts the response.
- `rsp_rdata`  out  32  load data; 0 for stores and errors.
- `rsp_err`  out  1  request was illegal.

## Operation

- FSM states: IDLE, WAIT, RESP. Reset state is IDLE.
- IDLE: `req_ready`=1. On `req_valid`: latch wen, addr, wdata, and be. Then go to WAIT, or go straight to RESP if `WAIT_CYCLES`=0. Also load the wait counter with `WAIT_CYCLES`.
- WAIT: `req_ready`=0. Decrement the counter each cycle. When the counter reaches 1, move to RESP on the next edge, so the FSM spends exactly `WAIT_CYCLES` cycles in WAIT.
- Commit happens on the edge that enters RESP:
  - Error check: `err` = (addr[1:0] != 0) OR (addr[31:ADDR_WIDTH+2] != 0).
  - Store without error: write the bytes enabled by be to word addr[ADDR_WIDTH+1:2]. Leave the other bytes unchanged. be = 0 is a legal no-op store.
  - Load without error: capture the full word into `rsp_rdata`. be is ignored.
  - Error: no memory change; `rsp_rdata`=0; `rsp_err`=1.
- RESP: `rsp_valid`=1. Outputs hold stable until `rsp_ready`=1, then return to IDLE.
- At most one request is outstanding; no pipelining.
- Every accepted request produces exactly one response, including stores.
- Memory contents are not reset and are undefined until written.

## Timing

- Reset values: `req_ready`=1, `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0, state IDLE, counter 0.
- Latency: acceptance edge at cycle T gives `rsp_valid` high from cycle T+1+`WAIT_CYCLES`.
- Throughput with `rsp_ready` tied high: one request per `WAIT_CYCLES`+2 cycles.
  - The IDLE cycle after the response handshake is mandatory; a new request is never accepted in the response handshake cycle.
- `req_ready` is a function of state only; no combinational path from `req_valid`.
- `rsp_valid`, `rsp_rdata`, and `rsp_err` are all registered outputs.
- `req_*` inputs are sampled only on the acceptance edge. Later changes are ignored.
- Reset asserted in WAIT: FSM returns to IDLE immediately, and the pending store is dropped (memory unchanged).
- Reset asserted in RESP: the committed store persists, and the response is discarded.
- Back-to-back requests to the same word: the second load observes the first store.

## Test plan

- Reset, then store 0xDEADBEEF with be=0xF at 0x10, then load 0x10 (`WAIT_CYCLES`=2):
  - Store response arrives 3 cycles after acceptance with rdata=0 and err=0.
  - Load returns 0xDEADBEEF with err=0.
- Partial store: with word 0x20 = 0x11223344, store 0xAABBCCDD with be=0b0101, then load 0x20 -> 0x11BB33DD.
- Misaligned load at 0x13, and store at 0x4000 when `ADDR_WIDTH`=10:
  - Each returns err=1 and rdata=0.
  - A following load of the target word shows no change.
- Backpressure: hold `rsp_ready`=0 for 5 cycles in RESP. `rsp_valid`, `rsp_rdata`, and `rsp_err` stay stable and `req_ready` stays 0. Release: the handshake completes and `req_ready`=1 on the next cycle.
- `WAIT_CYCLES`=0: a request accepted at T gives `rsp_valid` at T+1. Streaming 8 loads with `rsp_ready`=1 completes one response every 2 cycles.
- Assert `rst` while in WAIT on a store of 0x55 to 0x8 (word previously 0x0):
  - Outputs return to reset values asynchronously.
  - A subsequent load of 0x8 returns 0x0.
